// File: rtl/num_decoder.sv
// Index-to-one-hot decoder behind a 2-entry FIFO, 1-cycle latency, ready from registered state only.
// Optional NUM_DECODER_CNT_EN adds a saturating 8-bit output-transfer counter on xfer_cnt.
module num_decoder #(
  parameter int NUM_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_W-1:0]    num,
  input  logic                in_valid,
  output logic                in_ready,
`ifdef NUM_DECODER_CNT_EN
  output logic [7:0]          xfer_cnt,
`endif
  output logic [2**NUM_W-1:0] vector,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int VEC_W = 2**NUM_W;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state;
  logic [NUM_W-1:0] head;
  logic [NUM_W-1:0] tail;
  logic             push;
  logic             pop;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    vector = '0;
    if (out_valid) vector = VEC_W'(1) << head;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= num;
            state <= ONE;
          end
        end
        ONE: begin
          // With a simultaneous pop the incoming index replaces the head directly.
          if (push && pop) begin
            head <= num;
          end else if (push) begin
            tail  <= num;
            state <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head  <= tail;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef NUM_DECODER_CNT_EN
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (pop && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign xfer_cnt = cnt;
`endif

endmodule
